// File: rtl/data_checker_if.sv
// data_checker_if: groups the data_checker control, stream and status signals.
//   master : stimulus side (drives pattern/start/datain/datain_available, reads status)
//   slave  : data_checker side (reads stimulus, drives busy/done/pass/error/counts)
// With DATA_CHECKER_CAPTURE_EN defined, first-mismatch capture signals are added.
interface data_checker_if #(
  parameter int unsigned COUNT_WIDTH = 32
) ();
  logic [31:0]            pattern;
  logic                   start;
  logic [63:0]            datain;
  logic                   datain_available;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic                   error;
  logic [COUNT_WIDTH-1:0] error_count;
  logic [COUNT_WIDTH-1:0] word_count;
`ifdef DATA_CHECKER_CAPTURE_EN
  logic [COUNT_WIDTH-1:0] first_err_index;
  logic [63:0]            first_err_expected;
  logic [63:0]            first_err_received;

  modport master (
    output pattern, start, datain, datain_available,
    input  busy, done, pass, error, error_count, word_count,
    input  first_err_index, first_err_expected, first_err_received
  );
  modport slave (
    input  pattern, start, datain, datain_available,
    output busy, done, pass, error, error_count, word_count,
    output first_err_index, first_err_expected, first_err_received
  );
`else
  modport master (
    output pattern, start, datain, datain_available,
    input  busy, done, pass, error, error_count, word_count
  );
  modport slave (
    input  pattern, start, datain, datain_available,
    output busy, done, pass, error, error_count, word_count
  );
`endif
endinterface

// File: rtl/data_checker.sv
// data_checker: receive-side pattern checker. Regenerates the expected 64-bit
// word sequence for the selected pattern (0: byte-lane ramp, 1: counter,
// 2: walking rotate, 3: synthetic event) and compares each valid input word.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - data_checker_if.slave: pattern/start/datain/datain_available in;
//            busy/done/pass/error/error_count/word_count out (all registered)
// Parameters:
//   NUM_WORDS   - words per run; 0 runs until the next start
//   COUNT_WIDTH - width of word_count/error_count (must match the interface)
// Optional: define DATA_CHECKER_CAPTURE_EN to add first_err_index,
//   first_err_expected and first_err_received (first mismatch of a run).
module data_checker #(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  data_checker_if.slave bus
);

  localparam int unsigned DATA_W = 64;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [COUNT_WIDTH-1:0] NUM_WORDS_C = COUNT_WIDTH'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             pat_q, pat_d;
  logic [DATA_W-1:0]      exp_q, exp_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   error_q, error_d;
  logic [COUNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [COUNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [COUNT_WIDTH-1:0] err_cnt_inc_c, word_cnt_inc_c;
  logic                   mismatch_c;
`ifdef DATA_CHECKER_CAPTURE_EN
  logic [COUNT_WIDTH-1:0] cap_idx_q, cap_idx_d;
  logic [DATA_W-1:0]      cap_exp_q, cap_exp_d;
  logic [DATA_W-1:0]      cap_rcv_q, cap_rcv_d;
`endif

  // First expected word of a run for each pattern encoding.
  function automatic logic [DATA_W-1:0] seed_word(input logic [1:0] p);
    logic [DATA_W-1:0] w;
    w = '0;
    case (p)
      2'd0: w = 64'h0706_0504_0302_0100;
      2'd1: w = 64'h0;
      2'd2: w = 64'h1;
      default: w = {36'd1, 16'h0123, 8'd1, 4'd1};
    endcase
    return w;
  endfunction

  // Step the expected word once per consumed input word.
  function automatic logic [DATA_W-1:0] advance(input logic [1:0] p,
                                                input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    logic [35:0]       ts;
    logic [15:0]       amp;
    logic [7:0]        ch;
    logic [3:0]        id;
    r   = '0;
    ts  = w[63:28];
    amp = w[27:12];
    ch  = w[11:4];
    id  = w[3:0];
    case (p)
      2'd0: begin
        // Each byte lane counts by 8 independently; no carry across lanes.
        for (int i = 0; i < 8; i++) begin
          r[8*i +: 8] = w[8*i +: 8] + 8'd8;
        end
      end
      2'd1: r = w + 64'd1;
      2'd2: r = {w[62:0], w[63]};
      default: begin
        amp = {amp[14:0], amp[11] ^ amp[5] ^ amp[3]};
        ts  = ts + 36'd1;
        if (ch == 8'd255) begin
          ch = 8'd1;
          id = id + 4'd1;
        end else begin
          ch = ch + 8'd1;
        end
        // id 0 and 15 are reserved; the event id cycles 1..14.
        if (id == 4'd15) begin
          id = 4'd1;
        end
        r = {ts, amp, ch, id};
      end
    endcase
    return r;
  endfunction

  assign mismatch_c     = (bus.datain != exp_q);
  assign err_cnt_inc_c  = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + COUNT_WIDTH'(1);
  assign word_cnt_inc_c = (word_cnt_q == CNT_MAX) ? word_cnt_q : word_cnt_q + COUNT_WIDTH'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    exp_d      = exp_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    error_d    = error_q;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
`ifdef DATA_CHECKER_CAPTURE_EN
    cap_idx_d  = cap_idx_q;
    cap_exp_d  = cap_exp_q;
    cap_rcv_d  = cap_rcv_q;
`endif

    if (bus.start) begin
      // start wins over everything; a word presented alongside it is dropped.
      pat_d      = bus.pattern[1:0];
      exp_d      = seed_word(bus.pattern[1:0]);
      err_cnt_d  = '0;
      word_cnt_d = '0;
      pass_d     = 1'b0;
`ifdef DATA_CHECKER_CAPTURE_EN
      cap_idx_d  = '0;
      cap_exp_d  = '0;
      cap_rcv_d  = '0;
`endif
      if (bus.pattern > 32'd3) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        error_d = 1'b1;
      end else begin
        state_d = CHECK;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        error_d = 1'b0;
      end
    end else begin
      case (state_q)
        CHECK: begin
          if (bus.datain_available) begin
            // No resynchronisation: expected advances on every word.
            exp_d      = advance(pat_q, exp_q);
            word_cnt_d = word_cnt_inc_c;
            if (mismatch_c) begin
              err_cnt_d = err_cnt_inc_c;
              error_d   = 1'b1;
`ifdef DATA_CHECKER_CAPTURE_EN
              if (!error_q) begin
                cap_idx_d = word_cnt_q;
                cap_exp_d = exp_q;
                cap_rcv_d = bus.datain;
              end
`endif
            end
            if ((NUM_WORDS != 0) && (word_cnt_inc_c == NUM_WORDS_C)) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_cnt_d == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      exp_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      error_q    <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
`ifdef DATA_CHECKER_CAPTURE_EN
      cap_idx_q  <= '0;
      cap_exp_q  <= '0;
      cap_rcv_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      exp_q      <= exp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      error_q    <= error_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
`ifdef DATA_CHECKER_CAPTURE_EN
      cap_idx_q  <= cap_idx_d;
      cap_exp_q  <= cap_exp_d;
      cap_rcv_q  <= cap_rcv_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.error       = error_q;
  assign bus.error_count = err_cnt_q;
  assign bus.word_count  = word_cnt_q;
`ifdef DATA_CHECKER_CAPTURE_EN
  assign bus.first_err_index    = cap_idx_q;
  assign bus.first_err_expected = cap_exp_q;
  assign bus.first_err_received = cap_rcv_q;
`endif

endmodule

// File: tb/tb_data_checker.sv
// tb_data_checker: directed bench for data_checker. Two instances share one
// stimulus stream: u_dut4 (NUM_WORDS=4) for run-end behaviour and u_dut0
// (NUM_WORDS=0) for longer streams.
module tb_data_checker;

  logic clk;
  logic reset;

  data_checker_if #(.COUNT_WIDTH(32)) if4 ();
  data_checker_if #(.COUNT_WIDTH(32)) if0 ();

  data_checker #(.NUM_WORDS(4), .COUNT_WIDTH(32)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  data_checker #(.NUM_WORDS(0), .COUNT_WIDTH(32)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  assign if0.pattern          = if4.pattern;
  assign if0.start            = if4.start;
  assign if0.datain           = if4.datain;
  assign if0.datain_available = if4.datain_available;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] pat;
    logic [63:0] w0;
    logic [63:0] w1;
    logic [31:0] exp_ec;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] p, input logic avail, input logic [63:0] d);
    if4.start            = 1'b1;
    if4.pattern          = p;
    if4.datain_available = avail;
    if4.datain           = d;
    tick();
    if4.start            = 1'b0;
    if4.datain_available = 1'b0;
  endtask

  task automatic feed(input logic [63:0] d);
    if4.datain           = d;
    if4.datain_available = 1'b1;
    tick();
    if4.datain_available = 1'b0;
  endtask

  // Event-pattern reference step.
  function automatic logic [63:0] ev_next(input logic [63:0] w);
    logic [35:0] ts;
    logic [15:0] a;
    logic [7:0]  ch;
    logic [3:0]  id;
    {ts, a, ch, id} = w;
    a  = {a[14:0], a[11] ^ a[5] ^ a[3]};
    ts = ts + 36'd1;
    if (ch == 8'd255) begin
      ch = 8'd1;
      id = id + 4'd1;
    end else begin
      ch = ch + 8'd1;
    end
    if (id == 4'd15) id = 4'd1;
    return {ts, a, ch, id};
  endfunction

  // Byte-lane ramp word k: lane i holds (8k + i) mod 256.
  function automatic logic [63:0] ramp_word(input int k);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) begin
      w[8*i +: 8] = 8'((8 * k + i) % 256);
    end
    return w;
  endfunction

  initial begin
    logic [63:0] ev;

    tbl[0] = '{32'd0, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 32'd0};
    tbl[1] = '{32'd1, 64'h0, 64'h1, 32'd0};
    tbl[2] = '{32'd2, 64'h1, 64'h2, 32'd0};
    tbl[3] = '{32'd3, {36'd1, 16'h0123, 8'd1, 4'd1}, {36'd2, 16'h0247, 8'd2, 4'd1}, 32'd0};
    tbl[4] = '{32'd1, 64'h0, 64'h2, 32'd1};
    tbl[5] = '{32'd2, 64'h2, 64'h2, 32'd1};
    tbl[6] = '{32'd0, 64'h0, 64'h0F0E0D0C0B0A0908, 32'd1};
    tbl[7] = '{32'd3, 64'h0, 64'h0, 32'd2};

    reset                = 1'b0;
    if4.start            = 1'b0;
    if4.pattern          = '0;
    if4.datain           = '0;
    if4.datain_available = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_busy",  {63'd0, if4.busy},  64'd0);
    check("rst_done",  {63'd0, if4.done},  64'd0);
    check("rst_pass",  {63'd0, if4.pass},  64'd0);
    check("rst_error", {63'd0, if4.error}, 64'd0);
    check("rst_wc",    {32'd0, if4.word_count},  64'd0);
    check("rst_ec",    {32'd0, if4.error_count}, 64'd0);
`ifdef DATA_CHECKER_CAPTURE_EN
    check("rst_cap_idx", {32'd0, if4.first_err_index}, 64'd0);
`endif
    reset = 1'b1;
    tick();

    // Two-word vectors per pattern on the free-running instance
    for (int i = 0; i < 8; i++) begin
      do_start(tbl[i].pat, 1'b0, 64'd0);
      feed(tbl[i].w0);
      feed(tbl[i].w1);
      check($sformatf("tbl%0d_ec", i), {32'd0, if0.error_count}, {32'd0, tbl[i].exp_ec});
      check($sformatf("tbl%0d_wc", i), {32'd0, if0.word_count}, 64'd2);
      check($sformatf("tbl%0d_err", i), {63'd0, if0.error}, {63'd0, (tbl[i].exp_ec != 0)});
      check($sformatf("tbl%0d_busy", i), {63'd0, if0.busy}, 64'd1);
    end

    // Pattern 1, four-word run ends with pass
    do_start(32'd1, 1'b0, 64'd0);
    feed(64'd0);
    feed(64'd1);
    feed(64'd2);
    check("p1_done_early", {63'd0, if4.done}, 64'd0);
    feed(64'd3);
    check("p1_wc",   {32'd0, if4.word_count},  64'd4);
    check("p1_ec",   {32'd0, if4.error_count}, 64'd0);
    check("p1_done", {63'd0, if4.done}, 64'd1);
    check("p1_pass", {63'd0, if4.pass}, 64'd1);
    check("p1_busy", {63'd0, if4.busy}, 64'd0);
    feed(64'd4);
    check("p1_done_ignore_wc", {32'd0, if4.word_count}, 64'd4);
    check("p1_done_hold", {63'd0, if4.done}, 64'd1);

    // Pattern 2 with one bad word
    do_start(32'd2, 1'b0, 64'd0);
    feed(64'h1);
    feed(64'h2);
    feed(64'h4);
    feed(64'h9);
    feed(64'h10);
    check("p2_ec4",    {32'd0, if4.error_count}, 64'd1);
    check("p2_wc4",    {32'd0, if4.word_count},  64'd4);
    check("p2_error4", {63'd0, if4.error}, 64'd1);
    check("p2_pass4",  {63'd0, if4.pass},  64'd0);
    check("p2_done4",  {63'd0, if4.done},  64'd1);
    check("p2_ec0",    {32'd0, if0.error_count}, 64'd1);
    check("p2_wc0",    {32'd0, if0.word_count},  64'd5);
`ifdef DATA_CHECKER_CAPTURE_EN
    check("p2_cap_idx", {32'd0, if0.first_err_index}, 64'd3);
    check("p2_cap_exp", if0.first_err_expected, 64'h8);
    check("p2_cap_rcv", if0.first_err_received, 64'h9);
`endif

    // Pattern 0, 34 words with lane wrap
    do_start(32'd0, 1'b0, 64'd0);
    for (int k = 0; k < 34; k++) feed(ramp_word(k));
    check("p0_ec", {32'd0, if0.error_count}, 64'd0);
    check("p0_wc", {32'd0, if0.word_count},  64'd34);

    // Pattern 3, 256 events; last one built by hand for channel/id/timestamp
    do_start(32'd3, 1'b0, 64'd0);
    ev = {36'd1, 16'h0123, 8'd1, 4'd1};
    for (int k = 0; k < 255; k++) begin
      feed(ev);
      ev = ev_next(ev);
    end
    feed({36'd256, ev[27:12], 8'd1, 4'd2});
    check("p3_ec", {32'd0, if0.error_count}, 64'd0);
    check("p3_wc", {32'd0, if0.word_count},  64'd256);

    // Invalid pattern, then start with a simultaneous word
    do_start(32'd5, 1'b0, 64'd0);
    check("bad_done",  {63'd0, if4.done},  64'd1);
    check("bad_busy",  {63'd0, if4.busy},  64'd0);
    check("bad_error", {63'd0, if4.error}, 64'd1);
    check("bad_pass",  {63'd0, if4.pass},  64'd0);
    check("bad_wc",    {32'd0, if4.word_count},  64'd0);
    check("bad_ec",    {32'd0, if4.error_count}, 64'd0);
    do_start(32'd1, 1'b1, 64'd0);
    check("startdrop_wc",   {32'd0, if4.word_count}, 64'd0);
    check("startdrop_busy", {63'd0, if4.busy}, 64'd1);
    check("startdrop_err",  {63'd0, if4.error}, 64'd0);
    feed(64'd0);
    check("startdrop_seed_ec", {32'd0, if4.error_count}, 64'd0);
    check("startdrop_seed_wc", {32'd0, if4.word_count},  64'd1);

    // Reset mid-run
    do_start(32'd1, 1'b0, 64'd0);
    for (int k = 0; k < 10; k++) feed(64'(k));
    check("mid_wc", {32'd0, if0.word_count}, 64'd10);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_wc",   {32'd0, if0.word_count}, 64'd0);
    check("mid_rst_busy", {63'd0, if0.busy}, 64'd0);
    check("mid_rst_done", {63'd0, if4.done}, 64'd0);
    tick();
    reset = 1'b1;
    feed(64'd0);
    feed(64'd1);
    check("idle_ign_wc", {32'd0, if0.word_count}, 64'd0);
    check("idle_ign_ec", {32'd0, if0.error_count}, 64'd0);
    check("idle_busy",   {63'd0, if0.busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
